// File: rtl/minifloat_expand.sv
// Iterative decompressor: 7-bit minifloat {e, m} -> 11-bit unsigned integer, one shift per cycle.
// Optional macro MINIFLOAT_EXPAND_PIPE_EN lets HOLD accept the next code on the same edge it hands off.
module minifloat_expand #(
    parameter int EXP_W  = 3,
    parameter int MAN_W  = 4,
    parameter int DATA_W = MAN_W + 2**EXP_W - 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W-1:0] in_code,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_W-1:0]      out_data,
    output logic                   busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [DATA_W-1:0]  acc_q, acc_d;
    logic [EXP_W-1:0]   cnt_q, cnt_d;

    logic [EXP_W-1:0]   code_e;
    logic [MAN_W-1:0]   code_m;
    logic [DATA_W-1:0]  load_acc;
    logic [EXP_W-1:0]   load_cnt;
    logic               load;

    // Subnormal codes (e==0) carry no hidden one and need no shifting.
    assign code_e   = in_code[EXP_W+MAN_W-1:MAN_W];
    assign code_m   = in_code[MAN_W-1:0];
    assign load_acc = (code_e == '0) ? DATA_W'(code_m) : DATA_W'({1'b1, code_m});
    assign load_cnt = (code_e == '0) ? '0 : code_e - 1'b1;

`ifdef MINIFLOAT_EXPAND_PIPE_EN
    assign in_ready = (state_q == IDLE) || ((state_q == HOLD) && out_ready);
`else
    assign in_ready = (state_q == IDLE);
`endif

    assign load      = in_valid && in_ready;
    assign out_valid = (state_q == HOLD);
    assign out_data  = acc_q;
    assign busy      = (state_q != IDLE);

    always_comb begin
        // NOTE: every always_comb target gets a default first so no path can infer a latch.
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (load) begin
                    acc_d   = load_acc;
                    cnt_d   = load_cnt;
                    state_d = (load_cnt == '0) ? HOLD : SHIFT;
                end
            end
            SHIFT: begin
                acc_d = acc_q << 1;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == EXP_W'(1)) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = IDLE;
`ifdef MINIFLOAT_EXPAND_PIPE_EN
                    if (load) begin
                        acc_d   = load_acc;
                        cnt_d   = load_cnt;
                        state_d = (load_cnt == '0) ? HOLD : SHIFT;
                    end
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: doc/minifloat_expand.md
# minifloat_expand

Sequential decompressor for the 7-bit minifloat codes produced by the 11-bit integer compressor. It accepts one code per transaction over a valid/ready handshake. The mantissa is denormalised by an iterative one-bit-per-cycle shifter, and the result is presented as an 11-bit unsigned integer over a second valid/ready handshake. The block sits directly downstream of the compressor and recovers the integer value that the compressed code represents.

## Interface
- `EXP_W`, default 3: exponent field width.
- `MAN_W`, default 4: mantissa field width.
- `DATA_W`, default `MAN_W+2**EXP_W-1` (= 11): output width. Treated as derived; do not override.
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `in_valid`  in  1  upstream code valid.
- `in_ready`  out  1  block can accept a code this cycle.
- `in_code`  in  `EXP_W+MAN_W` (7)  code `{e[2:0], m[3:0]}`.
- `out_valid`  out  1  `out_data` holds a finished result.
- `out_ready`  in  1  downstream accepts the result.
- `out_data`  out  `DATA_W` (11)  expanded unsigned integer.
- `busy`  out  1  high in SHIFT or HOLD.

## Operation
- Decode rule:
  - `e==0`: value = `m` (0..15).
  - `e>0`: value = `{1'b1, m} << (e-1)`.
  - Maximum is `e=7`, `m=15`: 31<<6 = 1984 (0x7C0), which never overflows 11 bits.
- FSM states: IDLE, SHIFT, HOLD.
- IDLE:
  - `in_ready=1`.
  - On `in_valid && in_ready`, load `acc <= (e==0) ? m : {1,m}` and `cnt <= (e==0) ? 0 : e-1`.
  - Go to HOLD if the loaded `cnt==0`, otherwise go to SHIFT.
- SHIFT:
  - Each cycle `acc <= acc<<1` and `cnt <= cnt-1`.
  - Go to HOLD on the cycle where `cnt==1`, i.e. after the last shift.
- HOLD:
  - `out_valid=1`, `out_data=acc`.
  - On `out_valid && out_ready`, return to IDLE.
- `in_ready=0` in SHIFT and HOLD. The exception is HOLD when the Configuration macro is defined.
- `out_data` is driven from `acc` in every state. It is only meaningful while `out_valid=1`.
- Reset values: state=IDLE, `acc=0`, `cnt=0`, `out_valid=0`, `out_data=0`, `busy=0`, `in_ready=1` on the first cycle after reset deasserts.
- `rst_n` low in any state, including mid-SHIFT or HOLD with a pending result: the in-flight code is discarded with no output produced. The next accepted code decodes normally.

## Timing
- Code accepted at edge N gives `out_valid=1` from cycle N+1+k, where k = max(e-1, 0).
  - Minimum latency is 1 cycle (`e=0` or `e=1`).
  - Maximum latency is 7 cycles (`e=7`).
- Backpressure: while `out_valid && !out_ready`, `out_data` and `out_valid` are held stable and no new code is accepted, except as noted under Configuration.
- `in_code` is sampled only on the acceptance edge and may change freely otherwise.
- Upstream must keep `in_code` stable while `in_valid && !in_ready`. The block does not check this.

## Configuration
- `MINIFLOAT_EXPAND_PIPE_EN`
  - Defined:
    - In HOLD, `in_ready = out_ready`.
    - If an output transfer and an input transfer occur on the same edge, the new code is loaded and the FSM goes straight to HOLD or SHIFT, skipping IDLE.
    - Throughput for `e<=1` codes is one result per cycle.
  - Not defined:
    - In HOLD, `in_ready=0`.
    - Every transaction passes through IDLE, so there is a minimum of 2 cycles per result.

## Test plan
- Reset then `in_code=7'h05` (e=0, m=5): `out_data=5` with `out_valid=1` exactly 1 cycle after acceptance; `busy=1` during HOLD only.
- `in_code=7'h1A` (e=1, m=10): `out_data=26` after 1 cycle. `in_code=7'h7F` (e=7, m=15): `out_data=1984` (0x7C0) after 7 cycles, with `in_ready=0` throughout.
- `in_code=7'h3C` (e=3, m=12) with `out_ready` low for 5 cycles after `out_valid` rises: `out_data=112` held stable; `in_ready=0` all 5 cycles; transfer on the 6th cycle; return to IDLE.
- Accept `7'h7F`, then assert `rst_n=0` for one cycle at the third SHIFT cycle: `out_valid`, `out_data` and `busy` all read 0 after the reset edge. A following code `7'h20` (e=2, m=0) yields `out_data=32` after 2 cycles.
- `out_ready` tied high, codes 7'h01, 7'h12, 7'h03 presented back-to-back:
  - With `MINIFLOAT_EXPAND_PIPE_EN`: outputs 1, 18, 3 on consecutive cycles.
  - Without it: one bubble cycle between results.
- Exhaustive sweep of all 128 codes against the decode rule: every result is ≤2047, and the measured latency matches k for each code.
